axi_lite_slave_regfile: RTL and testbench
=========================================

AXI_LITE_SLAVE_REGFILE -- requirements
Module: axi_lite_slave_regfile

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, byte address of register 0.
REQ-002 SHALL have parameter NUM_REGS, default 4, number of 32-bit registers (power of two, 2..16).
REQ-003 SHALL have ports aclk input 1, clock; areset_n input 1, synchronous active-low reset.
REQ-004 SHALL have ports awaddr input 32, awvalid input 1, awready output 1 (write address channel).
REQ-005 SHALL have ports wdata input 32, wstrb input 4, wvalid input 1, wready output 1 (write data channel).
REQ-006 SHALL have ports bresp output 2, bvalid output 1, bready input 1 (write response channel).
REQ-007 SHALL have ports araddr input 32, arvalid input 1, arready output 1 (read address channel).
REQ-008 SHALL have ports rdata output 32, rresp output 2, rvalid output 1, rready input 1 (read data channel).

Function
REQ-009 SHALL treat a channel transfer as occurring on a rising aclk edge where valid and ready are both 1.
REQ-010 SHALL decode an address as in range iff BASE_ADDR <= addr < BASE_ADDR + 4*NUM_REGS; index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
REQ-011 SHALL run independent write and read paths; neither path stalls the other.
REQ-012 Write path SHALL hold flags aw_held and w_held; awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
REQ-013 On an AW transfer SHALL latch awaddr and set aw_held; on a W transfer SHALL latch wdata/wstrb and set w_held; AW and W may arrive in either order or the same cycle.
REQ-014 At the first edge where both address and data are available (held or transferring that edge), SHALL commit the write, clear both held flags, and set bvalid=1 from the next cycle.
REQ-015 Commit to an in-range register SHALL update byte k only where wstrb[k]=1, and SHALL set bresp=2'b00 (OKAY).
REQ-016 Commit to an out-of-range address SHALL leave all registers unchanged and set bresp=2'b10 (SLVERR).
REQ-017 bvalid and bresp SHALL stay stable until a B transfer; bvalid SHALL clear on the edge where bready=1.
REQ-018 Read path SHALL drive arready = !rvalid.
REQ-019 On an AR transfer SHALL set rvalid=1 from the next cycle with rdata = register[index], rresp=2'b00 if in range, else rdata=32'h0, rresp=2'b10.
REQ-020 rdata/rresp/rvalid SHALL stay stable until an R transfer; rvalid SHALL clear on the edge where rready=1; back-to-back reads SHALL have one idle arready-low cycle minimum (throughput one read per two cycles).
REQ-021 A read and a write commit to the same register at the same edge SHALL return the pre-write value.
REQ-022 Fastest write latency SHALL be AW+W in cycle N -> register updated and bvalid=1 in cycle N+1; fastest read: AR in cycle N -> rvalid=1 in cycle N+1.
REQ-023 valid inputs deasserting without a transfer SHALL have no effect on state.

Reset
REQ-024 While areset_n=0 at an edge SHALL clear all registers to 32'h0, aw_held, w_held, bvalid, rvalid to 0, bresp, rresp to 2'b00, rdata to 32'h0.
REQ-025 Reset asserted mid-transaction SHALL discard any held address/data and pending response; no register write SHALL occur on that edge.
REQ-026 After reset deassert SHALL present awready=1, wready=1, arready=1 in the first cycle.

Verification
REQ-027 AW 0x4 and W 0xDEADBEEF strb 4'hF same cycle, bready=1 -> bvalid next cycle bresp OKAY; read 0x4 -> rdata 0xDEADBEEF, rresp OKAY.
REQ-028 W 0x000000AA strb 4'b0001 three cycles before AW 0x8 (reg2 = 0x11223344) -> wready low after W, commit on AW, reg2 reads 0x112233AA.
REQ-029 AW 0x40 (out of range, NUM_REGS=4) with W 0xFFFFFFFF -> bresp SLVERR, all registers unchanged; read 0x40 -> rdata 0, rresp SLVERR.
REQ-030 bready held 0 for 5 cycles after bvalid -> bvalid/bresp stable, awready=wready=0 throughout; clear one cycle after bready=1.
REQ-031 Write 0x12345678 to 0x0 and AR 0x0 commit at same edge (reg0 previously 0) -> rdata 0x00000000, later read -> 0x12345678.
REQ-032 Assert areset_n=0 with aw_held=1 and rvalid=1 pending -> next cycle all valids 0, readies 1, registers 0, subsequent W alone causes no commit.

Source files
------------

// File: rtl/axi_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle for the register-file slave: five channels, master and slave views.
interface axi_lite_slave_regfile_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit byte-strobed registers at BASE_ADDR.
// Write and read paths are independent; all bus outputs come straight from flops.
module axi_lite_slave_regfile #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          NUM_REGS  = 4
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    axi_lite_slave_regfile_if.slave    bus
);

    localparam int          IDX_W        = $clog2(NUM_REGS);
    localparam logic [31:0] REGION_BYTES = 32'(4 * NUM_REGS);
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;

    // Bit 32 of the offset is the borrow: set when addr lies below BASE_ADDR.
    function automatic logic [32:0] addr_offset(input logic [31:0] addr);
        return {1'b0, addr} - {1'b0, BASE_ADDR};
    endfunction

    function automatic logic offset_in_range(input logic [32:0] off);
        return (off[32] == 1'b0) && (off[31:0] < REGION_BYTES);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = strb[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
        end
        return res;
    endfunction

    logic [31:0] regs_r [NUM_REGS];

    logic        aw_held_r, w_held_r, bvalid_r, rvalid_r;
    logic        awready_r, wready_r, arready_r;
    logic [31:0] awaddr_r, wdata_r, rdata_r;
    logic [3:0]  wstrb_r;
    logic [1:0]  bresp_r, rresp_r;

    logic        aw_held_nxt_s, w_held_nxt_s, bvalid_nxt_s, rvalid_nxt_s;
    logic [31:0] awaddr_nxt_s, wdata_nxt_s, rdata_nxt_s;
    logic [3:0]  wstrb_nxt_s;
    logic [1:0]  bresp_nxt_s, rresp_nxt_s;

    logic             aw_xfer_s, w_xfer_s, ar_xfer_s, commit_s;
    logic [31:0]      wr_addr_s, wr_data_s, rd_word_s;
    logic [3:0]       wr_strb_s;
    logic [32:0]      wr_off_s, rd_off_s;
    logic             wr_in_range_s, rd_in_range_s;
    logic [IDX_W-1:0] wr_idx_s, rd_idx_s;

    assign aw_xfer_s = bus.awvalid && awready_r;
    assign w_xfer_s  = bus.wvalid  && wready_r;
    assign ar_xfer_s = bus.arvalid && arready_r;

    // Held values win; otherwise use whatever is transferring this edge.
    assign wr_addr_s = aw_held_r ? awaddr_r : bus.awaddr;
    assign wr_data_s = w_held_r  ? wdata_r  : bus.wdata;
    assign wr_strb_s = w_held_r  ? wstrb_r  : bus.wstrb;
    assign commit_s  = (aw_held_r || aw_xfer_s) && (w_held_r || w_xfer_s);

    assign wr_off_s      = addr_offset(wr_addr_s);
    assign rd_off_s      = addr_offset(bus.araddr);
    assign wr_in_range_s = offset_in_range(wr_off_s);
    assign rd_in_range_s = offset_in_range(rd_off_s);
    assign wr_idx_s      = wr_off_s[IDX_W+1:2];
    assign rd_idx_s      = rd_off_s[IDX_W+1:2];
    assign rd_word_s     = rd_in_range_s ? regs_r[rd_idx_s] : 32'h0;

    // Next-state for write hold flags, write response and read response.
    always_comb begin
        aw_held_nxt_s = commit_s ? 1'b0 : (aw_held_r || aw_xfer_s);
        w_held_nxt_s  = commit_s ? 1'b0 : (w_held_r || w_xfer_s);
        awaddr_nxt_s  = aw_xfer_s ? bus.awaddr : awaddr_r;
        wdata_nxt_s   = w_xfer_s  ? bus.wdata  : wdata_r;
        wstrb_nxt_s   = w_xfer_s  ? bus.wstrb  : wstrb_r;

        bvalid_nxt_s = bvalid_r;
        bresp_nxt_s  = bresp_r;
        if (commit_s) begin
            bvalid_nxt_s = 1'b1;
            bresp_nxt_s  = wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_r && bus.bready) begin
            bvalid_nxt_s = 1'b0;
        end else begin
            bvalid_nxt_s = bvalid_r;
        end

        rvalid_nxt_s = rvalid_r;
        rdata_nxt_s  = rdata_r;
        rresp_nxt_s  = rresp_r;
        if (ar_xfer_s) begin
            rvalid_nxt_s = 1'b1;
            rdata_nxt_s  = rd_word_s;
            rresp_nxt_s  = rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_r && bus.rready) begin
            rvalid_nxt_s = 1'b0;
        end else begin
            rvalid_nxt_s = rvalid_r;
        end
    end

    // State, register file and registered ready outputs; reset discards everything in flight.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 32'h0;
            end
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awaddr_r  <= 32'h0;
            wdata_r   <= 32'h0;
            wstrb_r   <= 4'h0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0;
            rresp_r   <= 2'b00;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
            arready_r <= 1'b1;
        end else begin
            if (commit_s && wr_in_range_s) begin
                regs_r[wr_idx_s] <= merge_bytes(regs_r[wr_idx_s], wr_data_s, wr_strb_s);
            end
            aw_held_r <= aw_held_nxt_s;
            w_held_r  <= w_held_nxt_s;
            awaddr_r  <= awaddr_nxt_s;
            wdata_r   <= wdata_nxt_s;
            wstrb_r   <= wstrb_nxt_s;
            bvalid_r  <= bvalid_nxt_s;
            bresp_r   <= bresp_nxt_s;
            rvalid_r  <= rvalid_nxt_s;
            rdata_r   <= rdata_nxt_s;
            rresp_r   <= rresp_nxt_s;
            awready_r <= !aw_held_nxt_s && !bvalid_nxt_s;
            wready_r  <= !w_held_nxt_s && !bvalid_nxt_s;
            arready_r <= !rvalid_nxt_s;
        end
    end

    assign bus.awready = awready_r;
    assign bus.wready  = wready_r;
    assign bus.bvalid  = bvalid_r;
    assign bus.bresp   = bresp_r;
    assign bus.arready = arready_r;
    assign bus.rvalid  = rvalid_r;
    assign bus.rdata   = rdata_r;
    assign bus.rresp   = rresp_r;

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Bench for axi_lite_slave_regfile: vector table plus hand sequences, responses
// checked against a scoreboard of expected B/R beats.
module tb_axi_lite_slave_regfile;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    axi_lite_slave_regfile_if bus ();

    axi_lite_slave_regfile #(
        .BASE_ADDR (32'h0),
        .NUM_REGS  (4)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    logic [1:0] exp_b_q [$];
    r_exp_t     exp_r_q [$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endfunction

    function automatic void fail_now(input string name, input string msg);
        n_total++;
        $display("FAIL %s: %s", name, msg);
    endfunction

    // Response monitor: a beat completes at the next rising edge when valid && ready here.
    logic [1:0] mon_eb;
    r_exp_t     mon_er;
    always @(negedge aclk) begin
        if (areset_n && bus.bvalid && bus.bready) begin
            if (exp_b_q.size() == 0) begin
                fail_now("b_unexpected", $sformatf("bresp %0b with nothing expected", bus.bresp));
            end else begin
                mon_eb = exp_b_q.pop_front();
                chk("bresp", 32'(bus.bresp), 32'(mon_eb));
            end
        end
        if (areset_n && bus.rvalid && bus.rready) begin
            if (exp_r_q.size() == 0) begin
                fail_now("r_unexpected", $sformatf("rdata 0x%08h with nothing expected", bus.rdata));
            end else begin
                mon_er = exp_r_q.pop_front();
                chk("rdata", bus.rdata, mon_er.data);
                chk("rresp", 32'(bus.rresp), 32'(mon_er.resp));
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int c = 0; c < 40; c++) begin
            if (exp_b_q.size() == 0 && exp_r_q.size() == 0) break;
            @(posedge aclk); #1;
        end
        if (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
            fail_now({name, "_timeout"}, $sformatf("got %0d outstanding, required 0",
                     exp_b_q.size() + exp_r_q.size()));
            exp_b_q.delete();
            exp_r_q.delete();
        end
    endtask

    // Drives AW and/or W until each has transferred; response left to the monitor.
    task automatic do_write(input logic send_aw, input logic send_w, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb, input logic [1:0] resp);
        logic aw_go, w_go;
        exp_b_q.push_back(resp);
        bus.awaddr = addr; bus.awvalid = send_aw;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = send_w;
        for (int c = 0; c < 40 && (bus.awvalid || bus.wvalid); c++) begin
            @(negedge aclk);
            aw_go = bus.awvalid && bus.awready;
            w_go  = bus.wvalid && bus.wready;
            @(posedge aclk); #1;
            if (aw_go) bus.awvalid = 1'b0;
            if (w_go)  bus.wvalid  = 1'b0;
        end
        if (bus.awvalid || bus.wvalid) begin
            fail_now("write_handshake_timeout", "got no transfer, required one");
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        logic ar_go;
        exp_r_q.push_back('{data: data, resp: resp});
        bus.araddr = addr; bus.arvalid = 1'b1;
        for (int c = 0; c < 40 && bus.arvalid; c++) begin
            @(negedge aclk);
            ar_go = bus.arready;
            @(posedge aclk); #1;
            if (ar_go) bus.arvalid = 1'b0;
        end
        if (bus.arvalid) begin
            fail_now("read_handshake_timeout", "got no transfer, required one");
            bus.arvalid = 1'b0;
        end
        wait_drain("read");
    endtask

    vec_t vecs [13];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,        OKAY};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, OKAY};
        vecs[2]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, 32'h0,        OKAY};
        vecs[3]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h11223344, OKAY};
        vecs[4]  = '{1'b1, 32'h0C, 32'hA5A5A5A5, 4'hA, 32'h0,        OKAY};
        vecs[5]  = '{1'b0, 32'h0D, 32'h0,        4'h0, 32'hA500A500, OKAY};
        vecs[6]  = '{1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0,        SLVERR};
        vecs[7]  = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        SLVERR};
        vecs[8]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        OKAY};
        vecs[9]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, OKAY};
        vecs[10] = '{1'b0, 32'h10, 32'h0,        4'h0, 32'h0,        SLVERR};
        vecs[11] = '{1'b1, 32'h10, 32'h00000001, 4'hF, 32'h0,        SLVERR};
        vecs[12] = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'hA500A500, OKAY};

        bus.awaddr = 32'h0; bus.awvalid = 1'b0;
        bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = 32'h0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;

        areset_n = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready", 32'(bus.awready), 32'h1);
        chk("rst_wready",  32'(bus.wready),  32'h1);
        chk("rst_arready", 32'(bus.arready), 32'h1);
        chk("rst_bvalid",  32'(bus.bvalid),  32'h0);
        chk("rst_rvalid",  32'(bus.rvalid),  32'h0);
        chk("rst_rdata",   bus.rdata,        32'h0);
        areset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                do_write(1'b1, 1'b1, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
                wait_drain("vec_write");
            end else begin
                do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
            end
        end

        // W three cycles ahead of AW: data held, wready low until the commit.
        bus.wdata = 32'h000000AA; bus.wstrb = 4'b0001; bus.wvalid = 1'b1;
        @(negedge aclk);
        chk("early_w_wready", 32'(bus.wready), 32'h1);
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            chk("held_w_wready_low", 32'(bus.wready),  32'h0);
            chk("held_w_awready",    32'(bus.awready), 32'h1);
            chk("held_w_no_bvalid",  32'(bus.bvalid),  32'h0);
        end
        @(posedge aclk); #1;
        do_write(1'b1, 1'b0, 32'h08, 32'h0, 4'h0, OKAY);
        wait_drain("late_aw");
        do_read(32'h08, 32'h112233AA, OKAY);

        // Backpressured write response: stable until bready rises.
        bus.bready = 1'b0;
        do_write(1'b1, 1'b1, 32'h0C, 32'h0F0F0F0F, 4'hF, OKAY);
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            chk("bp_bvalid",  32'(bus.bvalid),  32'h1);
            chk("bp_bresp",   32'(bus.bresp),   32'(OKAY));
            chk("bp_awready", 32'(bus.awready), 32'h0);
            chk("bp_wready",  32'(bus.wready),  32'h0);
        end
        @(posedge aclk); #1;
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        chk("bp_bvalid_clear", 32'(bus.bvalid), 32'h0);
        wait_drain("bp");
        do_read(32'h0C, 32'h0F0F0F0F, OKAY);

        // Read and write commit to reg0 on the same edge: read returns old value.
        exp_b_q.push_back(OKAY);
        exp_r_q.push_back('{data: 32'h0, resp: OKAY});
        bus.awaddr = 32'h0; bus.awvalid = 1'b1;
        bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 32'h0; bus.arvalid = 1'b1;
        @(negedge aclk);
        chk("same_edge_awready", 32'(bus.awready), 32'h1);
        chk("same_edge_wready",  32'(bus.wready),  32'h1);
        chk("same_edge_arready", 32'(bus.arready), 32'h1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("fast_bvalid",     32'(bus.bvalid),  32'h1);
        chk("fast_rvalid",     32'(bus.rvalid),  32'h1);
        chk("ar_idle_arready", 32'(bus.arready), 32'h0);
        wait_drain("same_edge");
        do_read(32'h00, 32'h12345678, OKAY);

        // Reset with an address held and a read response pending.
        bus.rready = 1'b0;
        bus.araddr = 32'h04; bus.arvalid = 1'b1;
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        bus.awaddr = 32'h00; bus.awvalid = 1'b1;
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        chk("pre_rst_awready", 32'(bus.awready), 32'h0);
        chk("pre_rst_rvalid",  32'(bus.rvalid),  32'h1);
        areset_n = 1'b0;
        bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(posedge aclk); #1;
        areset_n = 1'b1;
        bus.wvalid = 1'b0;
        bus.rready = 1'b1;
        chk("mid_rst_bvalid",  32'(bus.bvalid),  32'h0);
        chk("mid_rst_rvalid",  32'(bus.rvalid),  32'h0);
        chk("mid_rst_awready", 32'(bus.awready), 32'h1);
        chk("mid_rst_wready",  32'(bus.wready),  32'h1);
        chk("mid_rst_arready", 32'(bus.arready), 32'h1);
        bus.wdata = 32'h00000055; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            chk("w_alone_no_bvalid", 32'(bus.bvalid),  32'h0);
            chk("w_alone_awready",   32'(bus.awready), 32'h1);
        end
        @(posedge aclk); #1;
        for (int r = 0; r < 4; r++) begin
            do_read(32'(4 * r), 32'h0, OKAY);
        end

        wait_drain("final");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
